// File: rtl/result_pkg.sv
// Shared types and geometry for the tile result serializer: lane vectors,
// per-tile tags and the row/column advance rule.
package result_pkg;

    localparam int NUM_LANES = 16;
    localparam int DATA_W    = 32;
    localparam int TILE_COLS = 3;
    localparam int TILE_ROWS = 1024;
    localparam int LANE_W    = $clog2(NUM_LANES);
    localparam int ROW_W     = $clog2(TILE_ROWS);
    localparam int COL_W     = $clog2(TILE_COLS);

    typedef logic [DATA_W-1:0] lane_vec_t [NUM_LANES];

    typedef struct packed {
        logic             sof;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } tile_tag_t;

    // Position of the tile that follows cur: column wraps into a row step.
    function automatic tile_tag_t advance_pos(input tile_tag_t cur);
        tile_tag_t nxt;
        nxt     = cur;
        nxt.sof = 1'b0;
        if (cur.col == COL_W'(TILE_COLS - 1)) begin
            nxt.col = '0;
            if (cur.row == ROW_W'(TILE_ROWS - 1)) begin
                nxt.row = '0;
            end else begin
                nxt.row = cur.row + ROW_W'(1);
            end
        end else begin
            nxt.col = cur.col + COL_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tile_fifo.sv
// DEPTH-entry tile buffer; the head entry is read straight from storage
// so it stays stable until popped.
module tile_fifo
    import result_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  lane_vec_t               push_data,
    input  tile_tag_t               push_tag,
    output lane_vec_t               head_data,
    output tile_tag_t               head_tag,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_data_r [DEPTH][NUM_LANES];
    tile_tag_t         mem_tag_r  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    // Storage write; payload needs no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_r[wr_ptr_r] <= push_data;
            mem_tag_r[wr_ptr_r]  <= push_tag;
        end
    end

    // Pointer and occupancy update; a push while full is only legal with a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_data_r[rd_ptr_r];
    assign head_tag  = mem_tag_r[rd_ptr_r];
    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign count     = count_r;

endmodule

// File: rtl/tile_result_serializer.sv
// Buffers parallel result tiles and replays them one lane per word on a
// valid/ready stream, tagged with row/column and frame markers.
module tile_result_serializer
    import result_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data [NUM_LANES],
    output logic              in_ready,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_last,
    output logic [ROW_W-1:0]  m_row,
    output logic [COL_W-1:0]  m_col,
    output logic [LANE_W-1:0] m_lane,
    output logic              overflow,
    output logic [15:0]       drop_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic [LANE_W-1:0] lane_r;
    logic [LANE_W-1:0] lane_nxt_s;
    tile_tag_t         pos_r;
    tile_tag_t         base_pos_s;
    tile_tag_t         push_tag_s;
    logic              overflow_r;
    logic [15:0]       drop_count_r;

    lane_vec_t         head_data_s;
    tile_tag_t         head_tag_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;

    logic              handshake_s;
    logic              last_word_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;

    assign handshake_s = (state_r == ST_SEND) && m_ready;
    assign last_word_s = (lane_r == LANE_W'(NUM_LANES - 1));
    assign pop_s       = handshake_s && last_word_s;
    // The final-word pop frees a slot in the same cycle, so a full buffer can still take a tile.
    assign push_s      = in_valid && (!fifo_full_s || pop_s);
    assign drop_s      = in_valid && fifo_full_s && !pop_s;

    tile_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (in_data),
        .push_tag  (push_tag_s),
        .head_data (head_data_s),
        .head_tag  (head_tag_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Tag of the incoming tile: a frame start restarts the grid at (0,0).
    always_comb begin
        if (in_sof) begin
            base_pos_s = '0;
        end else begin
            base_pos_s = pos_r;
        end
        push_tag_s     = base_pos_s;
        push_tag_s.sof = in_sof;
    end

    // Serializer next state; entering SEND on the write edge gives word 0 the following cycle.
    always_comb begin
        state_nxt_s = state_r;
        lane_nxt_s  = lane_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s || push_s) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
                lane_nxt_s = '0;
            end
            ST_SEND: begin
                if (handshake_s && last_word_s) begin
                    lane_nxt_s = '0;
                    if ((fifo_count_s > CNT_W'(1)) || push_s) begin
                        state_nxt_s = ST_SEND;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (handshake_s) begin
                    lane_nxt_s = lane_r + LANE_W'(1);
                end else begin
                    lane_nxt_s = lane_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                lane_nxt_s  = '0;
            end
        endcase
    end

    // Serializer state and lane counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            lane_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            lane_r  <= lane_nxt_s;
        end
    end

    // Grid position and drop bookkeeping; dropped tiles leave the grid untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_r        <= '0;
            overflow_r   <= 1'b0;
            drop_count_r <= 16'h0000;
        end else begin
            if (push_s) begin
                pos_r <= advance_pos(base_pos_s);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 16'hFFFF) begin
                    drop_count_r <= drop_count_r + 16'h0001;
                end
            end
        end
    end

    // Stream outputs come from the state register and the buffer head, zeroed when idle.
    always_comb begin
        m_valid = (state_r == ST_SEND);
        if (m_valid) begin
            m_data = head_data_s[lane_r];
            m_lane = lane_r;
            m_sof  = head_tag_s.sof && (lane_r == LANE_W'(0));
            m_last = last_word_s;
            m_row  = head_tag_s.row;
            m_col  = head_tag_s.col;
        end else begin
            m_data = '0;
            m_lane = '0;
            m_sof  = 1'b0;
            m_last = 1'b0;
            m_row  = '0;
            m_col  = '0;
        end
    end

    assign in_ready   = !fifo_full_s;
    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;

endmodule

// File: doc/tile_result_serializer.md
Name: tile_result_serializer

Overview:
- Drains the accelerator's parallel result port: one 16-lane × 32-bit tile per output_valid pulse.
- Re-emits each tile as a sequence of 32-bit words on a valid/ready stream, for a file-writer or DMA back end.
- Buffers tiles, tags each word with tile row/column and frame markers, and flags tiles lost to overflow; the upstream port has no backpressure.

Parameters:
- NUM_LANES, 16, words per tile (lanes of d_out)
- DATA_W, 32, bits per lane/word
- TILE_COLS, 3, tiles per row before column wraps
- TILE_ROWS, 1024, rows before row index wraps to 0
- DEPTH, 2, tile buffer entries (power of 2, ≥2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  tile present this cycle (single-cycle pulse per tile)
- in_sof  in  1  tile is first of frame
- in_data  in  NUM_LANES×DATA_W  unpacked lanes [NUM_LANES-1:0]
- in_ready  out  1  buffer not full (advisory; the source may ignore it)
- m_valid  out  1  output word valid
- m_ready  in  1  sink accepts word
- m_data  out  DATA_W  current word
- m_sof  out  1  word 0 of a tile marked in_sof
- m_last  out  1  word NUM_LANES-1 of a tile
- m_row  out  $clog2(TILE_ROWS)  tile row index
- m_col  out  $clog2(TILE_COLS)  tile column index
- m_lane  out  $clog2(NUM_LANES)  lane index of m_data
- overflow  out  1  sticky: a tile was dropped
- drop_count  out  16  dropped tiles, saturating at 0xFFFF

Behaviour:
- One clock (clk); reset is synchronous and active-high on rst.
- Reset (any cycle, including mid-tile):
  - FIFO emptied; state IDLE.
  - m_valid=0, m_sof=0, m_last=0, m_data=0, m_lane=0, m_row=0, m_col=0.
  - overflow=0, drop_count=0, in_ready=1.
  - Row/col tagging counters = 0.
- Tagging at write:
  - Each accepted tile stores its data, its sof bit, and the row/col computed at acceptance.
  - in_sof=1: the tile gets row=0, col=0; the next tile gets col=1.
  - Otherwise the tile gets the current counters. After acceptance, col increments; at TILE_COLS-1 it wraps to 0 and row increments; row wraps from TILE_ROWS-1 to 0.
  - Dropped tiles do not advance the counters.
- FIFO, DEPTH entries:
  - Write when in_valid and not full.
  - in_valid while full: tile discarded, overflow set, drop_count++ (saturating).
  - Simultaneous write and final-word pop while full: the write is accepted. The pop frees the entry in the same cycle, so this is not an overflow.
- Serializer FSM:
  - IDLE → SEND when FIFO non-empty.
  - In SEND, m_valid=1 and lane counter k selects m_data=head.data[k], m_lane=k.
  - m_sof = head.sof && k==0; m_last = (k==NUM_LANES-1).
  - On m_valid&&m_ready: k++. On the last word, pop the head and reset k=0. Stay in SEND if a next tile is present, else go to IDLE.
  - No bubble between back-to-back tiles.
- Latency:
  - Tile written at edge N → m_valid=1 from cycle N+1 with word 0.
  - Full tile with m_ready held high: NUM_LANES cycles.
- Stream rules:
  - m_data/m_lane/m_sof/m_last/m_row/m_col are stable while m_valid && !m_ready.
  - m_valid never drops before the handshake.
- in_ready = !full (combinational from FIFO count); it does not gate acceptance logic.
- Outputs are registered or driven from FIFO head registers. No combinational path from m_ready to m_valid.

Decomposition:
- Shared package `result_pkg`:
  - NUM_LANES, DATA_W
  - typedef lane_vec_t (unpacked DATA_W × NUM_LANES)
  - typedef tile_tag_t {sof, row, col}
- Sub-module `tile_fifo`: DEPTH-entry FIFO of {lane_vec_t, tile_tag_t}, with push/pop/full/empty/count.
- The serializer FSM, counters and drop logic stay in the top module.

Test Plan:
- Single tile, in_sof=1, lanes = 0x1000_0000+i, m_ready=1 → m_valid cycles N+1..N+16.
  - m_data 0x1000_0000..0x1000_000F, m_lane 0..15.
  - m_sof only on word 0, m_last only on word 15.
  - row=0, col=0.
- Four tiles (first with in_sof), spaced 20 cycles apart → tags (0,0),(0,1),(0,2),(1,0); 64 words, no gaps.
- Backpressure: m_ready toggles 1,0,0,1,… during a tile → every word appears exactly once, in order; outputs hold during stall cycles.
- Overflow: m_ready=0, three consecutive in_valid pulses → first two accepted, third dropped.
  - overflow=1, drop_count=1, in_ready=0 after the second tile.
  - Release m_ready → 32 words; row/col tags show no gap.
- Full write coinciding with the final-word pop: DEPTH=2 full, in_valid in the same cycle as lane-15 handshake → tile accepted, overflow stays 0.
- Reset asserted at word 7 of a tile → next cycle m_valid=0, FIFO empty, counters 0.
  - A new tile with in_sof starts at word 0, row/col (0,0).
